// File: rtl/xnor_popcount_acc.sv
// Binary-neuron accumulator: XNOR-popcount of activation/weight chunks into a
// saturating running sum, then a threshold compare that yields one output bit.
module xnor_popcount_acc #(
    parameter int CHUNK_W = 16,
    parameter int SUM_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    input  logic               in_last,
    input  logic [CHUNK_W-1:0] act_bits,
    input  logic [CHUNK_W-1:0] wgt_bits,
    input  logic [SUM_W-1:0]   threshold,
    output logic [SUM_W-1:0]   acc_sum,
    output logic               out_bit,
    output logic               out_valid,
    output logic               busy,
    output logic               overflow
);

    localparam int POP_W = $clog2(CHUNK_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        CMP
    } state_t;

    state_t           state_q, state_d;
    logic [SUM_W-1:0] acc_q, acc_d;
    logic             out_bit_q, out_bit_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             ovf_q, ovf_d;

    logic [POP_W-1:0] pop;
    logic [SUM_W-1:0] acc_base;
    logic [SUM_W:0]   sum_ext;
    logic             sat;
    logic [SUM_W-1:0] added;

    always_comb begin
        pop = '0;
        for (int i = 0; i < CHUNK_W; i++) begin
            pop = pop + POP_W'(act_bits[i] ~^ wgt_bits[i]);
        end
    end

    // A start on the same edge as a chunk makes that chunk the first one, so the
    // adder's base is forced to zero rather than the stale accumulator.
    always_comb begin
        acc_base = start ? '0 : acc_q;
        sum_ext  = {1'b0, acc_base} + (SUM_W + 1)'(pop);
        sat      = sum_ext[SUM_W];
        added    = sat ? '1 : sum_ext[SUM_W-1:0];
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        out_bit_d   = out_bit_q;
        out_valid_d = 1'b0;
        if (start) begin
            state_d = ACC;
            acc_d   = '0;
            ovf_d   = 1'b0;
            if (in_valid) begin
                acc_d = added;
                ovf_d = sat;
                if (in_last) begin
                    state_d = CMP;
                end
            end
        end else begin
            case (state_q)
                ACC: begin
                    if (in_valid) begin
                        acc_d = added;
                        ovf_d = ovf_q | sat;
                        if (in_last) begin
                            state_d = CMP;
                        end
                    end
                end
                CMP: begin
                    out_bit_d   = (acc_q >= threshold);
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            out_bit_q   <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            out_bit_q   <= out_bit_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            ovf_q       <= ovf_d;
        end
    end

    assign acc_sum   = acc_q;
    assign out_bit   = out_bit_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_xnor_popcount_acc.sv
// Self-checking bench for xnor_popcount_acc: a driver issues neurons and queues
// the expected compare result, a monitor pops and checks on every out_valid.
module tb_xnor_popcount_acc;

    logic        clk;
    logic        rst;
    logic        start, inValid, inLast;
    logic [15:0] actBits, wgtBits, threshold;
    logic [15:0] accSum;
    logic        outBit, outValid, busy, overflow;

    logic        sStart, sInValid, sInLast;
    logic [15:0] sAct, sWgt;
    logic [7:0]  sThreshold;
    logic [7:0]  sAccSum;
    logic        sOutBit, sOutValid, sBusy, sOverflow;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic        outB;
        logic [15:0] sum;
    } exp_t;

    exp_t expQ[$];

    xnor_popcount_acc #(.CHUNK_W(16), .SUM_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(inValid), .in_last(inLast),
        .act_bits(actBits), .wgt_bits(wgtBits), .threshold(threshold),
        .acc_sum(accSum), .out_bit(outBit), .out_valid(outValid), .busy(busy),
        .overflow(overflow)
    );

    xnor_popcount_acc #(.CHUNK_W(16), .SUM_W(8)) dutSmall (
        .clk(clk), .rst(rst), .start(sStart), .in_valid(sInValid), .in_last(sInLast),
        .act_bits(sAct), .wgt_bits(sWgt), .threshold(sThreshold),
        .acc_sum(sAccSum), .out_bit(sOutBit), .out_valid(sOutValid), .busy(sBusy),
        .overflow(sOverflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends even if the DUT stalls the driver.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] time limit exceeded");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic v, input logic l,
                                 input logic [15:0] a, input logic [15:0] w);
        start   = s;
        inValid = v;
        inLast  = l;
        actBits = a;
        wgtBits = w;
        @(posedge clk);
        #1;
    endtask

    // Reference: each neuron's result is min(sum of XNOR popcounts, 65535) >= threshold.
    task automatic runNeuron(input int n, input logic [15:0] thr, input int dataMode,
                             input bit gaps, input bit startAlone, input bit cancel);
        int          sum;
        int          expSum;
        logic [15:0] a, w;
        exp_t        e;
        threshold = thr;
        sum = 0;
        if (startAlone) applyStimulus(1'b1, 1'b0, 1'($urandom_range(0, 1)), 16'h0, 16'h0);
        for (int i = 0; i < n; i++) begin
            if (gaps && i > 0 && ($urandom % 3) == 0)
                applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
            case (dataMode)
                1:       begin a = 16'hA5A5; w = 16'hA5A5; end
                2:       begin a = 16'hFFFF; w = 16'h00FF; end
                default: begin a = 16'($urandom); w = 16'($urandom); end
            endcase
            sum += $countones(~(a ^ w));
            applyStimulus(!startAlone && i == 0, 1'b1, i == n - 1, a, w);
            if (i < n - 1) checkOutput("acc_running", 32'(accSum), sum);
        end
        expSum = (sum > 65535) ? 65535 : sum;
        if (!cancel) begin
            e.outB = (expSum >= int'(thr));
            e.sum  = 16'(expSum);
            expQ.push_back(e);
            checkOutput("acc_final", 32'(accSum), expSum);
            checkOutput("valid_early", 32'(outValid), 0);
            checkOutput("busy_in_cmp", 32'(busy), 1);
            applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
            checkOutput("valid_pulse", 32'(outValid), 1);
            checkOutput("busy_after_cmp", 32'(busy), 0);
            applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
            checkOutput("valid_single", 32'(outValid), 0);
        end
    endtask

    always @(negedge clk) begin
        if (outValid) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_out_valid", 32'(outValid), 0);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("sb_out_bit", 32'(outBit), 32'(e.outB));
                checkOutput("sb_acc_sum", 32'(accSum), 32'(e.sum));
            end
        end
    end

    initial begin
        rst = 1'b0;
        start = 0; inValid = 0; inLast = 0; actBits = 0; wgtBits = 0; threshold = 0;
        sStart = 0; sInValid = 0; sInLast = 0; sAct = 0; sWgt = 0; sThreshold = 8'd200;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        checkOutput("reset_acc", 32'(accSum), 0);
        checkOutput("reset_out_bit", 32'(outBit), 0);
        checkOutput("reset_out_valid", 32'(outValid), 0);
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_overflow", 32'(overflow), 0);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'($urandom_range(0, 1)), 16'hFFFF, 16'hFFFF);
            checkOutput("idle_acc", 32'(accSum), 0);
            checkOutput("idle_busy", 32'(busy), 0);
        end

        runNeuron(50, 16'd800, 1, 1'b0, 1'b0, 1'b0);
        runNeuron(50, 16'd801, 1, 1'b0, 1'b0, 1'b0);
        runNeuron(4, 16'd32, 2, 1'b0, 1'b0, 1'b0);
        checkOutput("overflow_clear", 32'(overflow), 0);

        for (int i = 0; i < 3; i++) applyStimulus(i == 0, 1'b1, 1'b0, 16'hA5A5, 16'hA5A5);
        checkOutput("mid_acc_sum", 32'(accSum), 48);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        checkOutput("restart_acc", 32'(accSum), 0);
        checkOutput("restart_busy", 32'(busy), 1);
        runNeuron(2, 16'd10, 0, 1'b0, 1'b0, 1'b0);

        runNeuron(3, 16'd20, 0, 1'b0, 1'b0, 1'b1);
        runNeuron(2, 16'd15, 0, 1'b1, 1'b0, 1'b0);
        runNeuron(2, 16'd15, 0, 1'b0, 1'b0, 1'b1);
        runNeuron(3, 16'd15, 0, 1'b0, 1'b1, 1'b0);

        for (int k = 0; k < 30; k++) begin
            int n;
            bit cancel;
            n = $urandom_range(1, 12);
            cancel = (k < 29) && (($urandom % 5) == 0);
            runNeuron(n, 16'($urandom_range(0, 16 * n)), 0, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), cancel);
        end

        applyStimulus(1'b1, 1'b1, 1'b0, 16'h1234, 16'h1234);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h00FF, 16'h00FF);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("async_acc", 32'(accSum), 0);
        checkOutput("async_busy", 32'(busy), 0);
        checkOutput("async_overflow", 32'(overflow), 0);
        checkOutput("async_out_valid", 32'(outValid), 0);
        start = 0; inValid = 0; inLast = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("async_after_busy", 32'(busy), 0);

        for (int j = 1; j <= 20; j++) begin
            logic [15:0] d;
            d = 16'($urandom);
            sStart = (j == 1); sInValid = 1'b1; sInLast = (j == 20); sAct = d; sWgt = d;
            @(posedge clk);
            #1;
            checkOutput("sat_acc", 32'(sAccSum), (16 * j > 255) ? 255 : 16 * j);
            checkOutput("sat_overflow", 32'(sOverflow), (16 * j > 255) ? 1 : 0);
        end
        sStart = 0; sInValid = 0; sInLast = 0;
        checkOutput("sat_valid_early", 32'(sOutValid), 0);
        @(posedge clk);
        #1;
        checkOutput("sat_valid", 32'(sOutValid), 1);
        checkOutput("sat_out_bit", 32'(sOutBit), 1);
        checkOutput("sat_hold_acc", 32'(sAccSum), 255);
        checkOutput("sat_hold_ovf", 32'(sOverflow), 1);
        sStart = 1'b1;
        @(posedge clk);
        #1;
        sStart = 1'b0;
        checkOutput("sat_clear_acc", 32'(sAccSum), 0);
        checkOutput("sat_clear_ovf", 32'(sOverflow), 0);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_empty", 32'(expQ.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
